interdevice_rx_assembler: RTL and testbench
===========================================

// Module: interdevice_rx_assembler
// PURPOSE
//   Assembles the byte stream from the inter-device UART receiver into whole
//   fixed-length packets and presents them to interdevice_controller.
//   - Frames each packet on a sync byte and enforces an inter-byte timeout.
//   - Holds each completed packet under a valid/ready handshake until the
//     controller accepts it.
// PARAMETERS
//   PACKET_BYTES    8      total bytes per packet: sync byte + payload + check byte
//   SYNC_BYTE       8'hA5  required value of byte 0
//   TIMEOUT_CYCLES  1024   maximum idle cycles allowed between bytes of one packet
// PORTS
//   clk            in   1                clock; all logic on posedge
//   rst            in   1                asynchronous, active-high reset
//   rx_byte        in   8                byte from the UART receiver
//   rx_valid       in   1                1-cycle strobe; rx_byte is valid when high
//   pkt_data       out  8*PACKET_BYTES   assembled packet; byte i at bits [8i+7:8i]
//   pkt_valid      out  1                pkt_data holds a complete packet
//   pkt_ready      in   1                controller accepts pkt_data this cycle
//   busy           out  1                high in COLLECT or HOLD
//   err_sync       out  1                1-cycle pulse: non-sync byte dropped in IDLE
//   err_timeout    out  1                1-cycle pulse: partial packet discarded on gap
//   err_overrun    out  1                1-cycle pulse: byte dropped while in HOLD
//   err_checksum   out  1                1-cycle pulse: check byte mismatch
// BEHAVIOUR
//   Reset (async assert, sync release)
//   - All outputs are 0, pkt_data is 0, state is IDLE, and both counters are 0.
//   - Asserting rst mid-packet clears everything immediately; no error pulse is generated.
//   FSM states: IDLE, COLLECT, HOLD
//   - IDLE: on rx_valid with rx_byte == SYNC_BYTE, store it as byte 0, set idx=1, go to COLLECT.
//     On rx_valid with any other value, drop the byte and pulse err_sync in the next cycle.
//   - COLLECT: each rx_valid stores rx_byte at index idx, increments idx, and clears the gap counter.
//     Sync-valued bytes here are treated as ordinary data.
//   - COLLECT, last byte (idx == PACKET_BYTES-1):
//     if the packet is accepted, go to HOLD; pkt_valid rises the cycle after the last byte (latency 1).
//     If it is rejected (checksum), go to IDLE.
//   - COLLECT, timeout: the gap counter increments on every cycle without rx_valid.
//     After TIMEOUT_CYCLES consecutive empty cycles, discard the partial packet, pulse err_timeout, go to IDLE.
//     rx_valid in the threshold cycle wins: the byte is stored and the counter is cleared.
//   - HOLD: pkt_valid=1, and pkt_data is stable until pkt_ready is sampled high.
//     On pkt_ready, pkt_valid is 0 from the next cycle and the state goes to IDLE.
//   - HOLD, dropped bytes: rx_valid without pkt_ready drops the byte and pulses err_overrun.
//   - HOLD, simultaneous events: pkt_ready together with rx_valid carrying SYNC_BYTE completes the
//     handshake and starts the new packet (idx=1, COLLECT). pkt_ready with a non-sync byte completes
//     the handshake and pulses err_sync.
//   - Before pkt_valid: pkt_ready is ignored while pkt_valid is 0.
//   Widths and counts
//   - idx is $clog2(PACKET_BYTES) bits; the gap counter is $clog2(TIMEOUT_CYCLES+1) bits and saturates.
//   - Error pulses are mutually exclusive per cycle and never coincide with a pkt_valid rising edge.
// CONFIGURATION
//   RX_ASSEMBLER_CHECKSUM_EN
//   - Defined: byte PACKET_BYTES-1 must equal the XOR of bytes 0..PACKET_BYTES-2.
//     On mismatch the packet is discarded, err_checksum pulses in the cycle after the last byte,
//     pkt_valid stays 0, and the state returns to IDLE.
//   - Undefined: the last byte is passed through unchecked, err_checksum is tied to 0,
//     and the port remains present.
// TESTING
//   1 Send A5 01 02 03 04 05 06 A2 with pkt_ready=1 ->
//     pkt_valid high 1 cycle after A2, pkt_data=64'hA2060504030201A5, no errors.
//   2 In IDLE, send 3C -> err_sync high exactly 1 cycle, busy=0, no pkt_valid.
//   3 Send A5 01 02, then idle for 1024 cycles -> err_timeout pulses once, busy=0;
//     then send A5..A2 -> correct packet.
//   4 Hold pkt_ready=0 for 20 cycles after a packet and inject 11 ->
//     err_overrun, pkt_data unchanged. Then pkt_ready=1 with A5 in the same cycle ->
//     handshake done, busy stays 1, next 7 bytes form packet 2.
//   5 Send A5 01 02 03 04 05 06 00 -> with RX_ASSEMBLER_CHECKSUM_EN: err_checksum pulse, no pkt_valid;
//     without it: pkt_valid with pkt_data=64'h00060504030201A5.
//   6 Assert rst after A5 01 02 -> all outputs 0 at once; after release, A5..A2 yields a correct packet.

Source files
------------

// File: rtl/interdevice_rx_assembler.sv
// interdevice_rx_assembler
//   Frames the byte stream from the inter-device UART receiver into fixed-length
//   packets. Each packet starts on a sync byte and must arrive without an
//   inter-byte gap of TIMEOUT_CYCLES or more. A completed packet is held under a
//   valid/ready handshake until the controller accepts it.
//
//   Optional feature macro: RX_ASSEMBLER_CHECKSUM_EN
//     defined   - last byte must equal the XOR of all preceding bytes; a mismatch
//                 discards the packet and pulses err_checksum.
//     undefined - last byte passes through unchecked; err_checksum is tied to 0.
//
// Ports
//   clk           clock, all logic on posedge
//   rst           asynchronous, active-high reset
//   rx_byte       byte from the UART receiver
//   rx_valid      1-cycle strobe qualifying rx_byte
//   pkt_data      assembled packet, byte i at [8i+7:8i]
//   pkt_valid     pkt_data holds a complete packet
//   pkt_ready     controller accepts pkt_data this cycle
//   busy          high while collecting or holding a packet
//   err_sync      pulse: non-sync byte dropped while idle
//   err_timeout   pulse: partial packet discarded after an inter-byte gap
//   err_overrun   pulse: byte dropped while holding a packet
//   err_checksum  pulse: check byte mismatch
module interdevice_rx_assembler #(
   parameter int unsigned PACKET_BYTES   = 8,
   parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [7:0]                rx_byte,
   input  logic                      rx_valid,
   output logic [8*PACKET_BYTES-1:0] pkt_data,
   output logic                      pkt_valid,
   input  logic                      pkt_ready,
   output logic                      busy,
   output logic                      err_sync,
   output logic                      err_timeout,
   output logic                      err_overrun,
   output logic                      err_checksum
);

   localparam int unsigned IdxW = $clog2(PACKET_BYTES);
   localparam int unsigned GapW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [IdxW-1:0] LastIdx = IdxW'(PACKET_BYTES - 1);
   localparam logic [GapW-1:0] GapMax  = GapW'(TIMEOUT_CYCLES);
   localparam logic [GapW-1:0] GapLast = GapW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {
      StIdle,
      StCollect,
      StHold
   } state_e;

   state_e                    state_q, state_d;
   logic [IdxW-1:0]           idx_q, idx_d;
   logic [GapW-1:0]           gap_q, gap_d;
   logic [8*PACKET_BYTES-1:0] data_q, data_d;
   logic                      err_sync_q, err_sync_d;
   logic                      err_timeout_q, err_timeout_d;
   logic                      err_overrun_q, err_overrun_d;
   logic                      csum_bad;
   logic                      last_byte;

   // Last byte of the packet arriving this cycle.
   assign last_byte = (state_q == StCollect) && rx_valid && (idx_q == LastIdx);

`ifdef RX_ASSEMBLER_CHECKSUM_EN
   logic [7:0] csum_calc;
   logic       err_csum_q;

   // Bytes 0..N-2 are already in data_q when the check byte arrives.
   always_comb begin
      csum_calc = '0;
      for (int i = 0; i < PACKET_BYTES - 1; i++) begin
         csum_calc = csum_calc ^ data_q[8*i +: 8];
      end
   end

   assign csum_bad = (rx_byte != csum_calc);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_csum_q <= 1'b0;
      end else begin
         err_csum_q <= last_byte && csum_bad;
      end
   end

   assign err_checksum = err_csum_q;
`else
   assign csum_bad     = 1'b0;
   assign err_checksum = 1'b0;
`endif

   always_comb begin
      state_d       = state_q;
      idx_d         = idx_q;
      gap_d         = gap_q;
      data_d        = data_q;
      err_sync_d    = 1'b0;
      err_timeout_d = 1'b0;
      err_overrun_d = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (rx_valid) begin
               if (rx_byte == SYNC_BYTE) begin
                  data_d       = '0;
                  data_d[7:0]  = rx_byte;
                  idx_d        = IdxW'(1);
                  gap_d        = '0;
                  state_d      = StCollect;
               end else begin
                  err_sync_d = 1'b1;
               end
            end
         end

         StCollect: begin
            if (rx_valid) begin
               data_d[{idx_q, 3'b000} +: 8] = rx_byte;
               gap_d = '0;
               if (last_byte) begin
                  idx_d   = '0;
                  state_d = csum_bad ? StIdle : StHold;
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end else if (gap_q == GapLast) begin
               // This empty cycle completes the allowed gap: drop the partial packet.
               err_timeout_d = 1'b1;
               idx_d         = '0;
               gap_d         = '0;
               state_d       = StIdle;
            end else if (gap_q != GapMax) begin
               gap_d = gap_q + 1'b1;
            end
         end

         StHold: begin
            if (pkt_ready) begin
               state_d = StIdle;
               idx_d   = '0;
               // A byte arriving with the handshake is treated as if already idle.
               if (rx_valid) begin
                  if (rx_byte == SYNC_BYTE) begin
                     data_d      = '0;
                     data_d[7:0] = rx_byte;
                     idx_d       = IdxW'(1);
                     gap_d       = '0;
                     state_d     = StCollect;
                  end else begin
                     err_sync_d = 1'b1;
                  end
               end
            end else if (rx_valid) begin
               err_overrun_d = 1'b1;
            end
         end

         default: begin
            state_d = StIdle;
            idx_d   = '0;
            gap_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= StIdle;
         idx_q         <= '0;
         gap_q         <= '0;
         data_q        <= '0;
         err_sync_q    <= 1'b0;
         err_timeout_q <= 1'b0;
         err_overrun_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         idx_q         <= idx_d;
         gap_q         <= gap_d;
         data_q        <= data_d;
         err_sync_q    <= err_sync_d;
         err_timeout_q <= err_timeout_d;
         err_overrun_q <= err_overrun_d;
      end
   end

   assign pkt_data    = data_q;
   assign pkt_valid   = (state_q == StHold);
   assign busy        = (state_q != StIdle);
   assign err_sync    = err_sync_q;
   assign err_timeout = err_timeout_q;
   assign err_overrun = err_overrun_q;

endmodule

// File: tb/tb_interdevice_rx_assembler.sv
// Randomised scoreboard bench for interdevice_rx_assembler. A packet-level
// reference model turns every applied input cycle into expected events (packet
// or error pulse, tagged with the cycle it must appear in); a separate monitor
// pops and compares them against what the DUT presents.
module tb_interdevice_rx_assembler;

   localparam int unsigned N    = 8;
   localparam logic [7:0]  SYNC = 8'hA5;
   localparam int unsigned TMO  = 1024;

   localparam int KPkt  = 0;
   localparam int KSync = 1;
   localparam int KTmo  = 2;
   localparam int KOvr  = 3;
   localparam int KCsum = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic [7:0]    rx_byte = '0;
   logic          rx_valid = 1'b0;
   logic [8*N-1:0] pkt_data;
   logic          pkt_valid;
   logic          pkt_ready = 1'b0;
   logic          busy;
   logic          err_sync, err_timeout, err_overrun, err_checksum;

   interdevice_rx_assembler #(
      .PACKET_BYTES  (N),
      .SYNC_BYTE     (SYNC),
      .TIMEOUT_CYCLES(TMO)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .rx_byte     (rx_byte),
      .rx_valid    (rx_valid),
      .pkt_data    (pkt_data),
      .pkt_valid   (pkt_valid),
      .pkt_ready   (pkt_ready),
      .busy        (busy),
      .err_sync    (err_sync),
      .err_timeout (err_timeout),
      .err_overrun (err_overrun),
      .err_checksum(err_checksum)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          kind;
      logic [63:0] data;
      int          cyc;
   } ev_t;

   ev_t        exp_q[$];
   int         n_cmp = 0;
   int         n_bad = 0;
   int         cyc   = 0;

   // Reference model state: bytes of the packet in progress, held flag, gap.
   logic [7:0] m_buf[$];
   bit         m_hold = 1'b0;
   int         m_gap  = 0;
   bit         exp_busy  = 1'b0;
   bit         exp_valid = 1'b0;
   logic [63:0] cur_data = '0;
   bit         rand_ready = 1'b0;

   function automatic string kname(input int k);
      case (k)
         KPkt:    return "packet";
         KSync:   return "err_sync";
         KTmo:    return "err_timeout";
         KOvr:    return "err_overrun";
         default: return "err_checksum";
      endcase
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (step %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic void push(input int k, input logic [63:0] d);
      ev_t e;
      e.kind = k;
      e.data = d;
      e.cyc  = cyc;
      exp_q.push_back(e);
   endfunction

   function automatic void start_or_reject(input logic [7:0] b);
      if (b == SYNC) begin
         m_buf.delete();
         m_buf.push_back(b);
         m_gap = 0;
      end else begin
         push(KSync, '0);
      end
   endfunction

   // One clock of the packet-level rules, applied to the inputs seen at this edge.
   function automatic void model_step(input bit v, input logic [7:0] b, input bit r);
      logic [63:0] d;
      logic [7:0]  x;
      if (m_hold) begin
         if (r) begin
            m_hold = 1'b0;
            if (v) start_or_reject(b);
         end else if (v) begin
            push(KOvr, '0);
         end
      end else if (m_buf.size() != 0) begin
         if (v) begin
            m_buf.push_back(b);
            m_gap = 0;
            if (m_buf.size() == N) begin
               d = '0;
               x = '0;
               for (int i = 0; i < N; i++) d[8*i +: 8] = m_buf[i];
               for (int i = 0; i < N - 1; i++) x = x ^ m_buf[i];
`ifdef RX_ASSEMBLER_CHECKSUM_EN
               if (x != m_buf[N-1]) begin
                  push(KCsum, '0);
               end else begin
                  push(KPkt, d);
                  m_hold = 1'b1;
               end
`else
               push(KPkt, d);
               m_hold = 1'b1;
`endif
               m_buf.delete();
            end
         end else begin
            m_gap++;
            if (m_gap == TMO) begin
               push(KTmo, '0);
               m_buf.delete();
               m_gap = 0;
            end
         end
      end else if (v) begin
         start_or_reject(b);
      end
      exp_busy  = m_hold || (m_buf.size() != 0);
      exp_valid = m_hold;
   endfunction

   task automatic drive(input bit v, input logic [7:0] b, input bit r);
      bit rr;
      rr = rand_ready ? 1'($urandom_range(0, 1)) : r;
      rx_valid  = v;
      rx_byte   = b;
      pkt_ready = rr;
      @(posedge clk);
      cyc++;
      model_step(v, b, rr);
      #1;
      rx_valid = 1'b0;
   endtask

   task automatic idle(input int n, input bit r);
      for (int i = 0; i < n; i++) drive(1'b0, 8'h00, r);
   endtask

   // Send bytes [first..N-1] of pk, with 'gap' empty cycles between bytes.
   task automatic send_from(input logic [63:0] pk, input int first, input int gap, input bit r);
      for (int i = first; i < N; i++) begin
         drive(1'b1, pk[8*i +: 8], r);
         if (i != N - 1) idle(gap, r);
      end
   endtask

   task automatic do_reset();
      rst       = 1'b1;
      rx_valid  = 1'b0;
      pkt_ready = 1'b0;
      #1;
      chk("rst_pkt_valid", {63'd0, pkt_valid}, 64'd0);
      chk("rst_pkt_data", pkt_data, 64'd0);
      chk("rst_busy", {63'd0, busy}, 64'd0);
      chk("rst_errs", {60'd0, err_sync, err_timeout, err_overrun, err_checksum}, 64'd0);
      exp_q.delete();
      m_buf.delete();
      m_hold    = 1'b0;
      m_gap     = 0;
      exp_busy  = 1'b0;
      exp_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   function automatic logic [63:0] make_pkt(input bit good);
      logic [63:0] p;
      logic [7:0]  x;
      p = {$urandom, $urandom};
      p[7:0] = SYNC;
      x = '0;
      for (int i = 0; i < N - 1; i++) x = x ^ p[8*i +: 8];
      p[8*(N-1) +: 8] = good ? x : (x ^ 8'(1 + $urandom_range(0, 254)));
      return p;
   endfunction

   task automatic observe(input int k);
      n_cmp++;
      if (exp_q.size() == 0 || exp_q[0].cyc > cyc) begin
         n_bad++;
         $display("FAIL unexpected_event: got %s expected none (step %0d)", kname(k), cyc);
      end else begin
         if (exp_q[0].kind != k) begin
            n_bad++;
            $display("FAIL event_kind: got %s expected %s (step %0d)", kname(k),
                     kname(exp_q[0].kind), cyc);
         end else if (k == KPkt) begin
            cur_data = exp_q[0].data;
            chk("pkt_data_first", pkt_data, cur_data);
         end
         void'(exp_q.pop_front());
      end
   endtask

   // Monitor: samples on the falling edge, away from the active edge.
   initial begin
      bit prev_valid;
      int nerr;
      prev_valid = 1'b0;
      forever begin
         @(negedge clk);
         if (rst) begin
            prev_valid = 1'b0;
         end else begin
            chk("busy", {63'd0, busy}, {63'd0, exp_busy});
            chk("pkt_valid", {63'd0, pkt_valid}, {63'd0, exp_valid});
            nerr = int'(err_sync) + int'(err_timeout) + int'(err_overrun) + int'(err_checksum);
            n_cmp++;
            if (nerr > 1 || (nerr != 0 && pkt_valid && !prev_valid)) begin
               n_bad++;
               $display("FAIL err_exclusive: got %0d pulses (valid rise %0b) expected at most 1",
                        nerr, pkt_valid && !prev_valid);
            end
            while (exp_q.size() != 0 && exp_q[0].cyc < cyc) begin
               n_cmp++;
               n_bad++;
               $display("FAIL missing_event: got nothing expected %s at step %0d",
                        kname(exp_q[0].kind), exp_q[0].cyc);
               void'(exp_q.pop_front());
            end
            if (pkt_valid && !prev_valid) observe(KPkt);
            if (err_sync) observe(KSync);
            if (err_timeout) observe(KTmo);
            if (err_overrun) observe(KOvr);
            if (err_checksum) observe(KCsum);
            if (pkt_valid) chk("pkt_data_stable", pkt_data, cur_data);
            prev_valid = pkt_valid;
         end
      end
   end

   initial begin
      logic [63:0] p;
      #1;
      do_reset();

      // Reference packet, controller always ready.
      send_from(64'hA2060504030201A5, 0, 0, 1'b1);
      idle(3, 1'b1);
      // Stray non-sync byte while idle.
      drive(1'b1, 8'h3C, 1'b1);
      idle(3, 1'b1);
      // Partial packet abandoned for a full timeout gap, then a clean packet.
      send_from(64'hA2060504030201A5, 0, 0, 1'b1);
      idle(0, 1'b1);
      drive(1'b1, 8'hA5, 1'b1);
      drive(1'b1, 8'h01, 1'b1);
      drive(1'b1, 8'h02, 1'b1);
      idle(TMO, 1'b1);
      idle(2, 1'b1);
      send_from(64'hA2060504030201A5, 0, 1, 1'b1);
      idle(2, 1'b1);
      // A byte arriving on the last allowed gap cycle keeps the packet alive.
      drive(1'b1, 8'hA5, 1'b1);
      idle(TMO - 1, 1'b1);
      send_from(64'hA2060504030201A5, 1, 0, 1'b1);
      idle(2, 1'b1);
      // Hold without ready, overrun byte, then handshake together with a new sync.
      send_from(64'h1122334455667788 & 64'hFFFF_FFFF_FFFF_FF00 | 64'hA5, 0, 0, 1'b0);
      idle(10, 1'b0);
      drive(1'b1, 8'h11, 1'b0);
      idle(9, 1'b0);
      drive(1'b1, SYNC, 1'b1);
      p = make_pkt(1'b1);
      send_from(p, 1, 0, 1'b1);
      idle(2, 1'b1);
      // Handshake together with a non-sync byte.
      send_from(64'hA2060504030201A5, 0, 0, 1'b0);
      idle(2, 1'b0);
      drive(1'b1, 8'h42, 1'b1);
      idle(2, 1'b1);
      // Wrong check byte.
      send_from(64'h00060504030201A5, 0, 0, 1'b1);
      idle(3, 1'b1);
      // Reset mid-packet, then a clean packet.
      drive(1'b1, 8'hA5, 1'b1);
      drive(1'b1, 8'h01, 1'b1);
      drive(1'b1, 8'h02, 1'b1);
      do_reset();
      send_from(64'hA2060504030201A5, 0, 0, 1'b1);
      idle(3, 1'b1);

      // Randomised traffic with random controller readiness.
      rand_ready = 1'b1;
      for (int it = 0; it < 80; it++) begin
         int sel;
         sel = int'($urandom_range(0, 19));
         if (sel < 12) begin
            send_from(make_pkt($urandom_range(0, 3) != 0), 0, int'($urandom_range(0, 2)), 1'b0);
         end else if (sel < 16) begin
            drive(1'b1, ($urandom_range(0, 2) == 0) ? SYNC : 8'($urandom), 1'b0);
         end else if (sel < 19) begin
            idle(int'($urandom_range(1, 20)), 1'b0);
         end else begin
            drive(1'b1, SYNC, 1'b0);
            drive(1'b1, 8'($urandom), 1'b0);
            idle(TMO - 2 + int'($urandom_range(0, 3)), 1'b0);
         end
      end
      rand_ready = 1'b0;
      idle(6, 1'b1);

      n_cmp++;
      if (exp_q.size() != 0) begin
         n_bad++;
         $display("FAIL drain: got %0d events outstanding expected 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
